// File: rtl/cv32e40p_if_stage_ctrl.sv
// Fetch-stage controller: DEPTH-entry instruction FIFO between prefetcher and aligner,
// IDLE/RUN/FLUSH control FSM, branch flush sequencing and a saturating miss counter.
module cv32e40p_if_stage_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic                     pc_set_i,
  input  logic                     fetch_valid_i,
  input  logic [DATA_W-1:0]        fetch_rdata_i,
  output logic                     fetch_ready_o,
  output logic                     branch_req_o,
  output logic                     instr_valid_o,
  output logic [DATA_W-1:0]        instr_rdata_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     perf_imiss_o,
  output logic [CNT_W-1:0]         miss_cnt_o,
  input  logic                     miss_cnt_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         occ_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                full, empty, push, pop;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  always_comb begin
    state_d       = state_q;
    fetch_ready_o = 1'b0;
    instr_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_valid_o = ~empty & ~pc_set_i;
        if (pc_set_i)   state_d = FLUSH;
        else if (req_i) state_d = RUN;
      end
      RUN: begin
        fetch_ready_o = req_i & ~full & ~pc_set_i;
        instr_valid_o = ~empty & ~pc_set_i;
        if (pc_set_i)    state_d = FLUSH;
        else if (!req_i) state_d = IDLE;
      end
      FLUSH: begin
        if (pc_set_i)   state_d = FLUSH;
        else if (req_i) state_d = RUN;
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push          = fetch_valid_i & fetch_ready_o;
  assign pop           = instr_valid_o & instr_ready_i;
  assign branch_req_o  = pc_set_i;
  assign perf_imiss_o  = pc_set_i | ((state_q == RUN) & empty & ~fetch_valid_i);
  assign instr_rdata_o = mem_q[rptr_q];
  assign occupancy_o   = occ_q;
  assign miss_cnt_o    = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_set_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        unique case ({push, pop})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  // Storage needs no reset: occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= fetch_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)                                cnt_q <= '0;
    else if (miss_cnt_clr_i)                cnt_q <= '0;
    else if (perf_imiss_o && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_cv32e40p_if_stage_ctrl.sv
// Scoreboard bench for cv32e40p_if_stage_ctrl: a queue-based reference model predicts
// handshakes, occupancy and miss counting; a monitor checks the buffer head against it.
module tb_cv32e40p_if_stage_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst, req_i, pc_set_i, fetch_valid_i, instr_ready_i, miss_cnt_clr_i;
  logic [DW-1:0] fetch_rdata_i;
  logic          fetch_ready_o, branch_req_o, instr_valid_o, perf_imiss_o;
  logic [DW-1:0] instr_rdata_o;
  logic [$clog2(DEPTH):0] occupancy_o;
  logic [CW-1:0] miss_cnt_o;

  always #5 clk = ~clk;

  cv32e40p_if_stage_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .pc_set_i(pc_set_i),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_ready_o(fetch_ready_o), .branch_req_o(branch_req_o),
    .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
    .instr_ready_i(instr_ready_i), .occupancy_o(occupancy_o),
    .perf_imiss_o(perf_imiss_o), .miss_cnt_o(miss_cnt_o),
    .miss_cnt_clr_i(miss_cnt_clr_i)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [DW-1:0] sb[$];
  bit            m_known = 0;
  bit            m_active = 0;
  bit            m_flush = 0;
  int            m_cnt = 0;
  int            m_miss = 0;
  bit            e_ready, e_valid, e_imiss;
  logic [DW-1:0] next_word = 32'h100;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: compare mid-cycle, advance at the rising edge.
  initial forever begin
    @(negedge clk); #1;
    e_ready = 0; e_valid = 0;
    if (!pc_set_i && !m_flush) begin
      e_valid = (m_cnt > 0);
      if (m_active) e_ready = req_i && (m_cnt < DEPTH);
    end
    e_imiss = pc_set_i || (m_active && !m_flush && m_cnt == 0 && !fetch_valid_i);
    if (m_known) begin
      check("occupancy", DW'(occupancy_o), DW'(m_cnt));
      check("fetch_ready", DW'(fetch_ready_o), DW'(e_ready));
      check("instr_valid", DW'(instr_valid_o), DW'(e_valid));
      check("branch_req", DW'(branch_req_o), DW'(pc_set_i));
      check("perf_imiss", DW'(perf_imiss_o), DW'(e_imiss));
      check("miss_cnt", DW'(miss_cnt_o), DW'(m_miss));
    end
    @(posedge clk);
    if (rst) begin
      sb.delete(); m_cnt = 0; m_active = 0; m_flush = 0; m_miss = 0; m_known = 1;
    end else if (m_known) begin
      if (miss_cnt_clr_i) m_miss = 0;
      else if (e_imiss && m_miss < (1 << CW) - 1) m_miss++;
      if (pc_set_i) begin
        sb.delete(); m_cnt = 0; m_flush = 1; m_active = 0;
      end else begin
        if (e_ready && fetch_valid_i) begin
          sb.push_back(fetch_rdata_i); m_cnt++; next_word += 4;
        end
        if (e_valid && instr_ready_i) m_cnt--;
        m_flush = 0; m_active = req_i;
      end
    end
  end

  // Monitor: whenever the head is presented it must equal the oldest expected word.
  initial forever begin
    @(negedge clk); #2;
    if (m_known && instr_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL head_unexpected at %0t: got 0x%0h expected no valid word", $time, instr_rdata_o);
      end else begin
        check("head_data", instr_rdata_o, sb[0]);
        if (instr_ready_i) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input bit r, input bit rq, input bit ps, input bit fv,
                     input bit ir, input bit cl, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r; req_i = rq; pc_set_i = ps; fetch_valid_i = fv;
      instr_ready_i = ir; miss_cnt_clr_i = cl; fetch_rdata_i = next_word;
    end
  endtask

  initial begin
    rst = 1; req_i = 0; pc_set_i = 0; fetch_valid_i = 0;
    instr_ready_i = 0; miss_cnt_clr_i = 0; fetch_rdata_i = '0;
    cyc(1, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 2);
    // fill to full, then drain in order
    cyc(0, 1, 0, 1, 0, 0, 7);
    cyc(0, 1, 0, 0, 1, 0, 6);
    // steady stream across pointer wraps
    cyc(0, 1, 0, 1, 1, 0, 16);
    // three entries, then redirect
    cyc(0, 1, 0, 1, 0, 0, 3);
    cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 2);
    // redirect together with push and pop attempts
    cyc(0, 1, 0, 1, 1, 0, 3);
    cyc(0, 1, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 1);
    // saturation of the miss counter, then clear during a miss
    cyc(0, 1, 0, 0, 1, 0, 20);
    cyc(0, 1, 0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 1, 0, 2);
    // reset during flush with words in flight
    cyc(0, 1, 0, 1, 0, 0, 2);
    cyc(0, 1, 1, 1, 0, 0, 1);
    cyc(1, 1, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst            = ($urandom_range(63) == 0);
      pc_set_i       = ($urandom_range(15) == 0);
      miss_cnt_clr_i = ($urandom_range(31) == 0);
      req_i          = ($urandom_range(9) < 8);
      fetch_valid_i  = ($urandom_range(9) < 6);
      instr_ready_i  = ($urandom_range(9) < 6);
      fetch_rdata_i  = $urandom;
    end
    cyc(0, 0, 0, 0, 1, 0, 2);
    @(negedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
